// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing, row/frame fetch pacing and aligned RGB565 output stage
module vga_timing_ctrl #(
  parameter int PIX_LAT    = 0,
  parameter bit SWAP_BYTES = 1,
  parameter int FETCH_LEN  = 8
) (
  input  logic        clk_25M,
  input  logic        rst_n_25M,
  input  logic        display_en,
  input  logic [15:0] pixel_data,
  output logic [9:0]  vga_h_counter,
  output logic [9:0]  vga_v_counter,
  output logic        start_frame,
  output logic        start_row,
  output logic        frame_done,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b
);
  localparam logic [9:0] H_MAX   = 10'd799;
  localparam logic [9:0] V_MAX   = 10'd524;
  localparam logic [9:0] ROW_END = 10'(640 + FETCH_LEN - 1);
  logic [9:0]       h_nx, v_nx;
  logic [15:0]      p, rgb_q;
  logic             act;
  logic [PIX_LAT:0] hs_sr, vs_sr, act_sr;
  always_comb begin
    h_nx = vga_h_counter == H_MAX ? '0 : vga_h_counter + 1'b1;
    v_nx = vga_h_counter != H_MAX ? vga_v_counter : vga_v_counter == V_MAX ? '0 : vga_v_counter + 1'b1;
    p    = SWAP_BYTES ? {pixel_data[7:0], pixel_data[15:8]} : pixel_data;
    act  = vga_h_counter < 10'd640 && vga_v_counter < 10'd480;
  end
  // fetch strobes are computed from the next position so they line up with the registered counters
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      vga_h_counter <= '0;
      vga_v_counter <= '0;
      start_frame   <= 1'b0;
      start_row     <= 1'b0;
      frame_done    <= 1'b0;
      hs_sr         <= '1;
      vs_sr         <= '1;
      act_sr        <= '0;
      rgb_q         <= '0;
    end else begin
      vga_h_counter <= h_nx;
      vga_v_counter <= v_nx;
      start_frame   <= v_nx == 10'd523;
      start_row     <= h_nx >= 10'd640 && h_nx <= ROW_END && (v_nx == V_MAX || v_nx <= 10'd478);
      frame_done    <= vga_h_counter == 10'd639 && vga_v_counter == 10'd479;
      hs_sr[0]      <= !(vga_h_counter >= 10'd656 && vga_h_counter <= 10'd751);
      vs_sr[0]      <= !(vga_v_counter >= 10'd490 && vga_v_counter <= 10'd491);
      act_sr[0]     <= act;
      for (int i = 1; i <= PIX_LAT; i++) begin
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        act_sr[i] <= act_sr[i-1];
      end
      rgb_q <= display_en ? p : '0;
    end
  end
  assign vga_hsync = hs_sr[PIX_LAT];
  assign vga_vsync = vs_sr[PIX_LAT];
  assign vga_r = act_sr[PIX_LAT] ? rgb_q[15:11] : '0;
  assign vga_g = act_sr[PIX_LAT] ? rgb_q[10:5]  : '0;
  assign vga_b = act_sr[PIX_LAT] ? rgb_q[4:0]   : '0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: frame-level reference model, directed pixel table and mid-frame reset
module tb_vga_timing_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [15:0] pix = '0;
  logic [9:0]  vh, vv;
  logic        sf, sr, fd, hs, vs;
  logic [4:0]  r, b;
  logic [5:0]  g;
  vga_timing_ctrl dut (
    .clk_25M(clk), .rst_n_25M(rst_n), .display_en(en), .pixel_data(pix),
    .vga_h_counter(vh), .vga_v_counter(vv), .start_frame(sf), .start_row(sr),
    .frame_done(fd), .vga_hsync(hs), .vga_vsync(vs), .vga_r(r), .vga_g(g), .vga_b(b)
  );
  always #20 clk = ~clk;
  typedef struct {
    int          h;
    int          v;
    logic [15:0] pix;
    logic        en;
    int          r;
    int          g;
    int          b;
  } vec_t;
  vec_t tbl[10];
  int vectors = 0, errors = 0;
  int hs_low = 0, vs_low = 0, fd_cnt = 0, sf_cnt = 0;
  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_reset(string tag);
    chk({tag, " h"}, vh, 0);
    chk({tag, " v"}, vv, 0);
    chk({tag, " start_frame"}, sf, 0);
    chk({tag, " start_row"}, sr, 0);
    chk({tag, " frame_done"}, fd, 0);
    chk({tag, " hsync"}, hs, 1);
    chk({tag, " vsync"}, vs, 1);
    chk({tag, " rgb"}, {r, g, b}, 0);
  endtask
  // Expected outputs n clocks after reset release; ppix/pen are the inputs of the previous cycle
  task automatic check_model(int n, logic [15:0] ppix, logic pen);
    int h, v, ph, pv, er, eg, eb, ehs, evs;
    logic [15:0] p;
    h = n % 800;
    v = (n / 800) % 525;
    chk("h", vh, h);
    chk("v", vv, v);
    chk("start_frame", sf, int'(v == 523));
    chk("start_row", sr, int'(h >= 640 && h < 648 && (v == 524 || v <= 478)));
    chk("frame_done", fd, int'(h == 640 && v == 479));
    ehs = 1; evs = 1; er = 0; eg = 0; eb = 0;
    if (n > 0) begin
      ph = (n - 1) % 800;
      pv = ((n - 1) / 800) % 525;
      ehs = int'(!(ph >= 656 && ph <= 751));
      evs = int'(!(pv >= 490 && pv <= 491));
      if (ph < 640 && pv < 480 && pen) begin
        p  = {ppix[7:0], ppix[15:8]};
        er = int'(p) / 2048;
        eg = (int'(p) / 32) % 64;
        eb = int'(p) % 32;
      end
    end
    chk("hsync", hs, ehs);
    chk("vsync", vs, evs);
    chk("r", r, er);
    chk("g", g, eg);
    chk("b", b, eb);
  endtask
  task automatic run(int cycles, bit stats);
    logic [15:0] ppix = '0;
    logic        pen = 1'b0;
    int          pt = -1;
    int          h, v;
    for (int n = 0; n < cycles; n++) begin
      check_model(n, ppix, pen);
      if (pt >= 0) begin
        chk($sformatf("tbl%0d r", pt), r, tbl[pt].r);
        chk($sformatf("tbl%0d g", pt), g, tbl[pt].g);
        chk($sformatf("tbl%0d b", pt), b, tbl[pt].b);
      end
      if (stats && n >= 1 && n <= 420000) begin
        hs_low += int'(!hs);
        vs_low += int'(!vs);
        fd_cnt += int'(fd);
      end
      if (stats && n < 420000) sf_cnt += int'(sf);
      h = n % 800;
      v = (n / 800) % 525;
      pt  = -1;
      pix = 16'($urandom);
      en  = $urandom_range(0, 7) != 0;
      for (int k = 0; k < 10; k++)
        if (tbl[k].h == h && tbl[k].v == v) begin
          pt  = k;
          pix = tbl[k].pix;
          en  = tbl[k].en;
        end
      ppix = pix;
      pen  = en;
      @(negedge clk);
    end
  endtask
  initial begin
    tbl[0] = '{0,   0,   16'h1234, 1'b1, 6,  32, 18};
    tbl[1] = '{5,   10,  16'h1FF8, 1'b1, 31, 0,  31};
    tbl[2] = '{639, 20,  16'hFFFF, 1'b1, 31, 63, 31};
    tbl[3] = '{640, 20,  16'hFFFF, 1'b1, 0,  0,  0};
    tbl[4] = '{799, 20,  16'hFFFF, 1'b1, 0,  0,  0};
    tbl[5] = '{100, 100, 16'hFFFF, 1'b0, 0,  0,  0};
    tbl[6] = '{100, 480, 16'hFFFF, 1'b1, 0,  0,  0};
    tbl[7] = '{639, 479, 16'hFFFF, 1'b1, 31, 63, 31};
    tbl[8] = '{0,   524, 16'hFFFF, 1'b1, 0,  0,  0};
    tbl[9] = '{300, 200, 16'h00FF, 1'b1, 31, 56, 0};
    pix = 16'hFFFF;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    run(421500, 1'b1);
    chk("hsync low per frame", hs_low, 50400);
    chk("vsync low per frame", vs_low, 1600);
    chk("frame_done pulses", fd_cnt, 1);
    chk("start_frame cycles", sf_cnt, 800);
    chk("pre-reset h", vh, 700);
    chk("pre-reset v", vv, 1);
    pix = 16'hFFFF;
    en  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    repeat (2) @(negedge clk);
    chk_reset("held reset");
    rst_n = 1'b1;
    run(800, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
